// File: rtl/alu_arith_seq.sv
// Slice-serial add/subtract unit: A+B, A-B, -B, B+1 over WIDTH bits,
// SLICE bits per clock, with N/Z/C/O flags and valid/ready on both sides.
module alu_arith_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_o
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("alu_arith_seq: WIDTH must be >= 2");
        end
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("alu_arith_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;      // conditioned operand A
    logic [WIDTH-1:0] b_q, b_d;      // conditioned operand B
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, o_q, o_d;

    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sum;
    logic             last;
    int               off;

    // One slice of the ripple chain, selected by the slice counter
    always_comb begin
        off  = int'(cnt_q) * SLICE;
        a_sl = a_q[off +: SLICE];
        b_sl = b_q[off +: SLICE];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        last = (cnt_q == CW'(NS - 1));
    end

    // Next-state and handshake outputs; operands are conditioned once at accept
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        z_d       = z_q;
        c_d       = c_q;
        o_d       = o_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = f[1] ? '0 : a;
                    b_d     = b ^ {WIDTH{f[1] ^ f[0]}};
                    carry_d = f[1] | f[0];
                    cnt_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[off +: SLICE] = sum[SLICE-1:0];
                carry_d = sum[SLICE];
                zacc_d  = zacc_q & (sum[SLICE-1:0] == '0);
                if (last) begin
                    // top slice holds the operand/result sign bits
                    n_d     = sum[SLICE-1];
                    z_d     = zacc_q & (sum[SLICE-1:0] == '0);
                    c_d     = sum[SLICE];
                    o_d     = (~a_sl[SLICE-1] & ~b_sl[SLICE-1] &  sum[SLICE-1]) |
                              ( a_sl[SLICE-1] &  b_sl[SLICE-1] & ~sum[SLICE-1]);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset discarding any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cnt_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            o_q     <= o_d;
        end
    end

    assign s      = s_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_o = o_q;

endmodule

// File: tb/tb_alu_arith_seq.sv
// Directed bench for alu_arith_seq: 32/8 main instance plus a 16/16 single-slice instance.
module tb_alu_arith_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  f = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [31:0] s;
    logic        fn, fz, fc, fo;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
    logic [1:0]  f16 = 2'b00;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16;
    logic [15:0] s16;
    logic        fn16, fz16, fc16, fo16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arith_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .f(f),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .flag_n(fn), .flag_z(fz), .flag_c(fc), .flag_o(fo));

    alu_arith_seq #(.WIDTH(16), .SLICE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .f(f16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .s(s16),
        .flag_n(fn16), .flag_z(fz16), .flag_c(fc16), .flag_o(fo16));

    // Present one op, scramble inputs after accept, return cycles until out_valid (99 = timeout)
    task automatic do_op(input logic [1:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int lat);
        @(negedge clk);
        f = op; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        f = 2'($urandom); a = $urandom; b = $urandom;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 32'h0 ||
            {fn, fz, fc, fo} !== 4'b0000) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b s=%h nzco=%b want rdy=1 vld=0 s=0 nzco=0000",
                     in_ready, out_valid, s, {fn, fz, fc, fo});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Each vector: op, a, b, expected s, expected NZCO
    task automatic test_ops;
        logic [1:0]  ops [7];
        logic [31:0] va  [7];
        logic [31:0] vb  [7];
        logic [31:0] es  [7];
        logic [3:0]  ef  [7];
        int lat;
        ops[0] = 2'b00; va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; es[0] = 32'h80000000; ef[0] = 4'b1001;
        ops[1] = 2'b01; va[1] = 32'h00000005; vb[1] = 32'h00000005; es[1] = 32'h00000000; ef[1] = 4'b0110;
        ops[2] = 2'b10; va[2] = 32'h00001234; vb[2] = 32'h80000000; es[2] = 32'h80000000; ef[2] = 4'b1001;
        ops[3] = 2'b10; va[3] = 32'h00001234; vb[3] = 32'h00000003; es[3] = 32'hFFFFFFFD; ef[3] = 4'b1000;
        ops[4] = 2'b11; va[4] = 32'hDEADBEEF; vb[4] = 32'hFFFFFFFF; es[4] = 32'h00000000; ef[4] = 4'b0110;
        ops[5] = 2'b11; va[5] = 32'h00000000; vb[5] = 32'h0000007F; es[5] = 32'h00000080; ef[5] = 4'b0000;
        ops[6] = 2'b00; va[6] = 32'h00FF00FF; vb[6] = 32'h01010101; es[6] = 32'h02000200; ef[6] = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            do_op(ops[i], va[i], vb[i], lat);
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL op%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if (s !== es[i] || {fn, fz, fc, fo} !== ef[i]) begin
                errors++;
                $display("FAIL op%0d_result: s=%h nzco=%b want s=%h nzco=%b",
                         i, s, {fn, fz, fc, fo}, es[i], ef[i]);
            end
            release_out();
        end
    endtask

    // DONE stall for 3 cycles, then release while a new op is already offered
    task automatic test_back_to_back;
        int lat;
        do_op(2'b00, 32'h7FFFFFFF, 32'h00000001, lat);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 32'h80000000 ||
                {fn, fz, fc, fo} !== 4'b1001) begin
                errors++;
                $display("FAIL done_hold%0d: vld=%b rdy=%b s=%h nzco=%b want 1 0 80000000 1001",
                         i, out_valid, in_ready, s, {fn, fz, fc, fo});
            end
        end
        f = 2'b01; a = 32'h00000003; b = 32'h00000005; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_release: vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        // op held on the inputs is taken on this edge, not the release edge
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: rdy=%b want 0", in_ready);
        end
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        checks++;
        if (lat !== 4 || s !== 32'hFFFFFFFE || {fn, fz, fc, fo} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d s=%h nzco=%b want lat=4 s=fffffffe nzco=1000",
                     lat, s, {fn, fz, fc, fo});
        end
        release_out();
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        @(negedge clk);
        f = 2'b00; a = 32'h12345678; b = 32'h11111111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 32'h0 ||
            {fn, fz, fc, fo} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b s=%h nzco=%b want 1 0 0 0000",
                     in_ready, out_valid, s, {fn, fz, fc, fo});
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_single_slice;
        int lat;
        @(negedge clk);
        f16 = 2'b00; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        a16 = 16'h0; b16 = 16'h0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid16) begin lat = i; break; end
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL w16_latency: got %0d want 1", lat);
        end
        checks++;
        if (s16 !== 16'h0000 || {fn16, fz16, fc16, fo16} !== 4'b0110) begin
            errors++;
            $display("FAIL w16_result: s=%h nzco=%b want s=0000 nzco=0110",
                     s16, {fn16, fz16, fc16, fo16});
        end
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_idle: rdy=%b vld=%b want 1 0", in_ready16, out_valid16);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_mid_run();
        test_single_slice();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
